// File: rtl/rvne_pkg.sv
// Shared opcode constants, hazard FSM encoding and register-usage decode
// for the hazard/stall unit.
package rvne_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_VLOAD  = 7'b0000010;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_VEC  = 1'b1
  } hs_state_e;

  localparam logic VSEL_WVR = 1'b0;
  localparam logic VSEL_SVR = 1'b1;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_VLOAD: uses_rs1 = 1'b1;
      default:                                                    uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_STORE, OP_RTYPE, OP_BRANCH: uses_rs2 = 1'b1;
      default:                       uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vec_beat_counter.sv
// Beat counter for multi-beat vector loads: runs 0..VEC_WORDS-1 once per start,
// flags the terminal beat, and clears on abort.
module vec_beat_counter #(
  parameter int VEC_WORDS = 8,
  parameter int BEAT_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              last,
  output logic [BEAT_W-1:0] beat
);

  logic run;

  assign last = run && (beat == BEAT_W'(VEC_WORDS - 1));

  // Abort beats everything, so a branch on the terminal beat still clears cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= 1'b0;
      beat <= '0;
    end else if (abort) begin
      run  <= 1'b0;
      beat <= '0;
    end else if (start) begin
      run  <= 1'b1;
      beat <= '0;
    end else if (last) begin
      run  <= 1'b0;
      beat <= '0;
    end else if (run) begin
      beat <= beat + BEAT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detection, vector-load beat sequencing and branch flush.
// Optional stall performance counter under macro HAZARD_PERF_EN.
module hazard_stall_unit
  import rvne_pkg::*;
#(
  parameter int VEC_WORDS = 8,
  parameter int BEAT_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rd,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              flush,
  output logic              vec_valid,
  output logic [BEAT_W-1:0] vec_beat,
  output logic              vec_sel
`ifdef HAZARD_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_stall_cnt
`endif
);

  hs_state_e state, state_d;
  logic      hazard, vstart, stall_c, last;

  assign hazard = ex_memread && (ex_rd != 5'd0) &&
                  ((uses_rs1(id_opcode) && (ex_rd == id_rs1)) ||
                   (uses_rs2(id_opcode) && (ex_rd == id_rs2)));

  always_comb begin
    state_d = state;
    stall_c = 1'b0;
    vstart  = 1'b0;
    case (state)
      HS_IDLE: begin
        if (!ex_branch_taken) begin
          if (hazard) begin
            stall_c = 1'b1;
          end else if (id_opcode == OP_VLOAD) begin
            stall_c = 1'b1;
            vstart  = 1'b1;
            state_d = HS_VEC;
          end
        end
      end
      HS_VEC: begin
        if (ex_branch_taken) begin
          state_d = HS_IDLE;
        end else begin
          stall_c = !last;
          if (last) state_d = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HS_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      vec_sel <= VSEL_WVR;
    else if (vstart) vec_sel <= (id_funct3 >= 3'd3) ? VSEL_SVR : VSEL_WVR;
  end

  vec_beat_counter #(
    .VEC_WORDS (VEC_WORDS),
    .BEAT_W    (BEAT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (vstart),
    .abort (ex_branch_taken),
    .last  (last),
    .beat  (vec_beat)
  );

  // Stall is forced low while reset is held so the decoder sees reset values
  // even if ID still presents a hazard or a vector load.
  assign stall      = rst_n && stall_c;
  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign flush      = ex_branch_taken;
  assign vec_valid  = (state == HS_VEC);

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 perf_stall_cnt <= '0;
    else if (perf_clr)                          perf_stall_cnt <= '0;
    else if (stall && (perf_stall_cnt != '1))   perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scenarios followed by random stimulus, checked against a queue-based
// model of the stall/beat rules.
module tb_hazard_stall_unit;
  import rvne_pkg::*;

  localparam int VW = 8;
  localparam int BW = 3;
  localparam logic [6:0] OP_NOP = 7'b0110111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    id_opcode;
  logic [2:0]    id_funct3;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          ex_memread, ex_branch_taken;
  logic          stall, pc_write, ifid_write, flush, vec_valid, vec_sel;
  logic [BW-1:0] vec_beat;
`ifdef HAZARD_PERF_EN
  logic          perf_clr;
  logic [31:0]   perf_stall_cnt;
`endif

  hazard_stall_unit #(.VEC_WORDS(VW), .BEAT_W(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write), .flush(flush),
    .vec_valid(vec_valid), .vec_beat(vec_beat), .vec_sel(vec_sel)
`ifdef HAZARD_PERF_EN
    , .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          vq[$];          // beats still to be issued, front = current beat
  logic        msel = 1'b0;
  logic [31:0] mcnt = '0;
  logic        last_stall, last_valid;

  function automatic bit reads1(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_VLOAD};
  endfunction
  function automatic bit reads2(input logic [6:0] op);
    return op inside {OP_STORE, OP_RTYPE, OP_BRANCH};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2);
    id_opcode = op; id_funct3 = f3; id_rs1 = r1; id_rs2 = r2;
  endtask

  task automatic set_ex(input logic mr, input logic [4:0] rd, input logic br);
    ex_memread = mr; ex_rd = rd; ex_branch_taken = br;
  endtask

  // Inputs are applied just after a falling edge; check, advance the model, wait.
  task automatic step();
    bit idle, haz, vs, es;
    idle = (vq.size() == 0);
    haz  = idle && ex_memread && (ex_rd != 0) &&
           ((reads1(id_opcode) && ex_rd == id_rs1) || (reads2(id_opcode) && ex_rd == id_rs2));
    vs   = idle && (id_opcode == OP_VLOAD) && !haz && !ex_branch_taken;
    es   = !ex_branch_taken && (haz || vs || vq.size() > 1);
    #1;
    last_stall = stall;
    last_valid = vec_valid;
    chk("stall", stall, es);
    chk("pc_write", pc_write, !es);
    chk("ifid_write", ifid_write, !es);
    chk("flush", flush, ex_branch_taken);
    chk("vec_valid", vec_valid, !idle);
    chk("vec_beat", vec_beat, idle ? 0 : vq[0]);
    if (!idle) chk("vec_sel", vec_sel, msel);
`ifdef HAZARD_PERF_EN
    chk("perf_cnt", perf_stall_cnt, mcnt);
    if (perf_clr) mcnt = '0;
    else if (es && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
`endif
    if (ex_branch_taken) vq.delete();
    else if (vs) begin
      for (int i = 0; i < VW; i++) vq.push_back(i);
      msel = (id_funct3 >= 3);
    end else if (!idle) void'(vq.pop_front());
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_pc_write"}, pc_write, 1);
    chk({tag, "_ifid_write"}, ifid_write, 1);
    chk({tag, "_vec_valid"}, vec_valid, 0);
    chk({tag, "_vec_beat"}, vec_beat, 0);
    chk({tag, "_vec_sel"}, vec_sel, 0);
`ifdef HAZARD_PERF_EN
    chk({tag, "_perf"}, perf_stall_cnt, 0);
`endif
  endtask

  initial begin
    int scnt;
    logic [6:0] ops [8];
    ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_VLOAD, OP_VLOAD, OP_NOP};
    rst_n = 1'b0;
    set_id(OP_NOP, 0, 0, 0);
    set_ex(0, 0, 0);
`ifdef HAZARD_PERF_EN
    perf_clr = 1'b0;
`endif
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs1, then the load moves on and the hazard clears
    set_ex(1, 5, 0); set_id(OP_RTYPE, 0, 5, 1); step();
    chk("s1_stall", last_stall, 1);
    set_ex(0, 0, 0); step();
    chk("s1_clear", last_stall, 0);

    // x0 destination never stalls
    set_ex(1, 0, 0); set_id(OP_RTYPE, 0, 0, 1); step();
    chk("s2_x0", last_stall, 0);

    // I-type does not read rs2
    set_ex(1, 7, 0); set_id(OP_ITYPE, 0, 9, 7); step();
    chk("s3_rs2_unused", last_stall, 0);

    // WVR vector load: 8 stall cycles, beats 0..7
    set_ex(0, 0, 0); set_id(OP_VLOAD, 1, 2, 0);
    scnt = 0;
    repeat (VW) begin step(); scnt += int'(last_stall); end
    step();
    chk("s4_last_beat_stall", last_stall, 0);
    set_id(OP_NOP, 0, 0, 0); step();
    chk("s4_stall_cycles", scnt, VW);

    // SVR vector load flushed at beat 3
    set_id(OP_VLOAD, 4, 2, 0);
    repeat (4) step();
    set_ex(0, 0, 1); step();
    chk("s5_flush_stall", last_stall, 0);
    set_ex(0, 0, 0); set_id(OP_NOP, 0, 0, 0); step();
    chk("s5_after_valid", last_valid, 0);

    // Reset at beat 5
    set_id(OP_VLOAD, 0, 0, 0);
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    check_reset_vals("s6_reset");
    vq.delete(); msel = 1'b0; mcnt = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use followed by one vector load
    set_ex(1, 3, 0); set_id(OP_RTYPE, 0, 1, 3); step();
    set_ex(0, 0, 0); set_id(OP_VLOAD, 0, 1, 0);
    repeat (VW + 1) step();
    set_id(OP_NOP, 0, 0, 0); step();
`ifdef HAZARD_PERF_EN
    chk("s6_perf_total", perf_stall_cnt, 9);
`endif

    // Back-to-back vector loads
    set_id(OP_VLOAD, 5, 0, 0);
    repeat (2 * VW + 2) step();

    // Random traffic
    repeat (600) begin
      set_id(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      set_ex(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
`ifdef HAZARD_PERF_EN
      perf_clr = ($urandom_range(0, 39) == 0);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
